sprite_pos_arbiter: RTL and testbench
=====================================

// Module: sprite_pos_arbiter
// PURPOSE
//  Shared write controller for the sprite position table read by the LCD pixel pipeline.
//  Arbitrates NUM_REQ requesters (game logic, demo movers) onto one table write port, round-robin.
//  Double-buffered: writes land in a shadow table; the active table is copied from shadow once per frame at vblank.
//  Active outputs therefore never change mid-scan, so sprites do not tear.
// PARAMETERS
//  NUM_REQ  2    number of requesters (>=1)
//  NUM_SPR  4    number of sprite slots (<= 2**IDX_W)
//  IDX_W    2    slot index width
//  H_MAX    480  horizontal visible width; x >= H_MAX wraps to 0
//  V_MAX    272  vertical visible height; y >= V_MAX wraps to 0
// PORTS
//  PixelClk   in   1             pixel clock, single clock domain
//  nRST       in   1             reset, synchronous, active-low
//  frame_start in  1             one-cycle pulse at the first vblank line, from the timing generator
//  req_valid  in   NUM_REQ       per-requester write request
//  req_ready  out  NUM_REQ       per-requester grant; transfer = valid & ready
//  req_slot   in   NUM_REQ*IDX_W target slot, requester i at [i*IDX_W +: IDX_W]
//  req_x      in   NUM_REQ*16    x position, requester i at [i*16 +: 16]
//  req_y      in   NUM_REQ*16    y position, requester i at [i*16 +: 16]
//  req_en     in   NUM_REQ       sprite visible flag
//  spr_x      out  NUM_SPR*16    active x per slot
//  spr_y      out  NUM_SPR*16    active y per slot
//  spr_en     out  NUM_SPR       active visible flag per slot
//  commit_done out 1             one-cycle pulse after the active table updates
//  wr_err     out  1             sticky flag: a write targeted slot >= NUM_SPR
// BEHAVIOUR
//  Reset (nRST low at an edge): shadow and active tables are all 0, spr_en=0, commit_done=0, wr_err=0,
//   rr pointer=0, state=S_RUN. Reset applies mid-commit and mid-transfer; a pending transfer is lost.
//  FSM S_RUN:
//   - grant = first requester with valid, searching from the rr pointer upward, modulo NUM_REQ.
//   - req_ready is combinational: req_ready[i] = (state==S_RUN) & grant[i]. At most one bit is high.
//   - On a transfer by requester i, the rr pointer becomes (i+1) mod NUM_REQ.
//   - When no request is valid, the rr pointer does not change.
//   - A requester holds valid and its data stable until ready is high. Only the granted requester completes.
//   - A transfer writes the shadow slot at the same edge: x (or 0 if x>=H_MAX), y (or 0 if y>=V_MAX), en.
//   - A transfer with slot >= NUM_SPR completes and is discarded, and sets wr_err at that edge.
//   - frame_start=1 at edge k: state goes to S_COMMIT. A transfer at edge k is still written to shadow
//     and is included in the commit.
//  FSM S_COMMIT (exactly one cycle):
//   - req_ready is all 0.
//   - At edge k+1 the whole active table is loaded from shadow, and state returns to S_RUN.
//   - commit_done is high for the cycle after edge k+1 (registered).
//   - frame_start during S_COMMIT is ignored.
//  Latency: a write accepted at edge t appears on spr_* at the first commit edge at or after t.
//   There is no path from shadow to spr_* outside a commit.
//  Shadow retains its contents across commits. Slots not written in a frame keep their value.
//  Arithmetic: coordinates are unsigned 16 bit. Wrap compares use >=. No modular reduction beyond the single wrap to 0.
// CONFIGURATION
//  SPR_AUTOMOVE_EN defined:
//   - At each commit edge, every slot whose shadow was not written since the previous commit is moved:
//     x+1 and y+1 in both shadow and active.
//   - x wraps from H_MAX-1 to 0; y wraps from V_MAX-1 to 0.
//   - A per-slot dirty bit tracks this. Dirty bits are cleared at the commit edge and by reset.
//   - Slots with spr_en=0 also move.
//  SPR_AUTOMOVE_EN undefined:
//   - No dirty bits. The commit is a pure shadow-to-active copy.
// TESTING
//  1. Reset: hold nRST=0 for 2 cycles -> spr_x/spr_y/spr_en all 0, req_ready=0 while no request is valid,
//     wr_err=0, commit_done=0.
//  2. Buffering: req0 writes slot1 with x=100, y=50, en=1 -> spr_* unchanged until frame_start.
//     After frame_start at edge k, slot1 reads (100,50,1) after edge k+1, and commit_done is high one cycle.
//  3. Round robin: req0 and req1 held valid continuously -> grants alternate 0,1,0,1.
//     With only req1 valid after pointer=1 -> req1 granted back-to-back.
//  4. Wrap/error: write x=480, y=272 -> 0,0 after commit. Write slot 4 with NUM_SPR=4 -> accepted,
//     table unchanged, wr_err=1 until reset.
//  5. Collision: transfer at the same edge as frame_start -> included in the commit, and req_ready=0 in
//     the next cycle. Assert nRST in S_COMMIT -> active stays 0.
//  6. SPR_AUTOMOVE_EN: slot0 at (479,271), not written, one commit -> (0,0). Slot2 written (10,10) in the
//     same frame -> (10,10).

Source files
------------

// File: rtl/sprite_pos_arbiter.sv
// rtl/sprite_pos_arbiter.sv - round-robin double-buffered sprite position table writer (optional SPR_AUTOMOVE_EN)
module sprite_pos_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int NUM_SPR = 4,
    parameter int IDX_W   = 2,
    parameter int H_MAX   = 480,
    parameter int V_MAX   = 272
) (
    input  logic                     PixelClk,
    input  logic                     nRST,
    input  logic                     frame_start,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*IDX_W-1:0] req_slot,
    input  logic [NUM_REQ*16-1:0]    req_x,
    input  logic [NUM_REQ*16-1:0]    req_y,
    input  logic [NUM_REQ-1:0]       req_en,
    output logic [NUM_SPR*16-1:0]    spr_x,
    output logic [NUM_SPR*16-1:0]    spr_y,
    output logic [NUM_SPR-1:0]       spr_en,
    output logic                     commit_done,
    output logic                     wr_err
);

    localparam int             PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0]    H_LIM   = 16'(H_MAX);
    localparam logic [15:0]    V_LIM   = 16'(V_MAX);
    localparam logic [IDX_W:0] SPR_LIM = (IDX_W + 1)'(NUM_SPR);

    typedef enum logic {S_RUN, S_COMMIT} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [NUM_REQ-1:0] grant;
    logic               grant_found;
    int                 gidx;
    int                 srch_idx;
    logic               xfer;

    logic [IDX_W-1:0]   w_slot;
    logic [15:0]        w_x_raw, w_y_raw, w_x, w_y;
    logic               w_en;
    logic               w_slot_ok;

    logic [15:0]        sh_x_q  [NUM_SPR];
    logic [15:0]        sh_y_q  [NUM_SPR];
    logic               sh_en_q [NUM_SPR];
    logic [15:0]        act_x_q [NUM_SPR];
    logic [15:0]        act_y_q [NUM_SPR];
    logic               act_en_q[NUM_SPR];
    logic [15:0]        cmt_x   [NUM_SPR];
    logic [15:0]        cmt_y   [NUM_SPR];
    logic               commit_done_q;
    logic               wr_err_q;
`ifdef SPR_AUTOMOVE_EN
    logic [NUM_SPR-1:0] dirty_q;
`endif

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        gidx        = 0;
        srch_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            srch_idx = int'(rr_q) + k;
            if (srch_idx >= NUM_REQ) srch_idx = srch_idx - NUM_REQ;
            if (!grant_found && req_valid[srch_idx]) begin
                grant_found    = 1'b1;
                gidx           = srch_idx;
                grant[srch_idx] = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == S_RUN) ? grant : '0;
    assign xfer      = |req_ready;

    assign w_slot    = req_slot[gidx*IDX_W +: IDX_W];
    assign w_x_raw   = req_x[gidx*16 +: 16];
    assign w_y_raw   = req_y[gidx*16 +: 16];
    assign w_en      = req_en[gidx];
    assign w_x       = (w_x_raw >= H_LIM) ? 16'd0 : w_x_raw;
    assign w_y       = (w_y_raw >= V_LIM) ? 16'd0 : w_y_raw;
    assign w_slot_ok = ({1'b0, w_slot} < SPR_LIM);

    // Next state and round-robin pointer; frame_start is ignored while committing
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            S_RUN: begin
                if (xfer) rr_d = (gidx == NUM_REQ - 1) ? '0 : PTR_W'(gidx + 1);
                if (frame_start) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    // Values loaded into the active table at the commit edge
    always_comb begin
        for (int i = 0; i < NUM_SPR; i++) begin
`ifdef SPR_AUTOMOVE_EN
            if (dirty_q[i]) begin
                cmt_x[i] = sh_x_q[i];
                cmt_y[i] = sh_y_q[i];
            end else begin
                cmt_x[i] = (sh_x_q[i] >= H_LIM - 16'd1) ? 16'd0 : sh_x_q[i] + 16'd1;
                cmt_y[i] = (sh_y_q[i] >= V_LIM - 16'd1) ? 16'd0 : sh_y_q[i] + 16'd1;
            end
`else
            cmt_x[i] = sh_x_q[i];
            cmt_y[i] = sh_y_q[i];
`endif
        end
    end

    // FSM state and arbitration pointer registers
    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            state_q <= S_RUN;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Shadow writes during run, shadow-to-active copy at the commit edge
    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                sh_x_q[i]   <= '0;
                sh_y_q[i]   <= '0;
                sh_en_q[i]  <= 1'b0;
                act_x_q[i]  <= '0;
                act_y_q[i]  <= '0;
                act_en_q[i] <= 1'b0;
            end
            commit_done_q <= 1'b0;
            wr_err_q      <= 1'b0;
`ifdef SPR_AUTOMOVE_EN
            dirty_q       <= '0;
`endif
        end else begin
            commit_done_q <= (state_q == S_COMMIT);
            if (state_q == S_COMMIT) begin
                for (int i = 0; i < NUM_SPR; i++) begin
                    act_x_q[i]  <= cmt_x[i];
                    act_y_q[i]  <= cmt_y[i];
                    act_en_q[i] <= sh_en_q[i];
`ifdef SPR_AUTOMOVE_EN
                    sh_x_q[i]   <= cmt_x[i];
                    sh_y_q[i]   <= cmt_y[i];
`endif
                end
`ifdef SPR_AUTOMOVE_EN
                dirty_q <= '0;
`endif
            end
            if (xfer) begin
                if (w_slot_ok) begin
                    sh_x_q[w_slot]  <= w_x;
                    sh_y_q[w_slot]  <= w_y;
                    sh_en_q[w_slot] <= w_en;
`ifdef SPR_AUTOMOVE_EN
                    dirty_q[w_slot] <= 1'b1;
`endif
                end else begin
                    wr_err_q <= 1'b1;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SPR; g++) begin : g_out
            assign spr_x[g*16 +: 16] = act_x_q[g];
            assign spr_y[g*16 +: 16] = act_y_q[g];
            assign spr_en[g]         = act_en_q[g];
        end
    endgenerate

    assign commit_done = commit_done_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_sprite_pos_arbiter.sv
// tb/tb_sprite_pos_arbiter.sv - scoreboard bench for sprite_pos_arbiter
module tb_sprite_pos_arbiter;

    localparam int NR = 2;
    localparam int NS = 4;
    localparam int IW = 3;
    localparam int HM = 480;
    localparam int VM = 272;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           fs = 1'b0;
    logic [NR-1:0]  valid = '0;
    logic [NR-1:0]  ready;
    logic [NR*IW-1:0] slot = '0;
    logic [NR*16-1:0] rx = '0;
    logic [NR*16-1:0] ry = '0;
    logic [NR-1:0]  ren = '0;
    logic [NS*16-1:0] sx, sy;
    logic [NS-1:0]  sen;
    logic           cd, werr;

    always #5 clk = ~clk;

    sprite_pos_arbiter #(
        .NUM_REQ(NR), .NUM_SPR(NS), .IDX_W(IW), .H_MAX(HM), .V_MAX(VM)
    ) dut (
        .PixelClk(clk), .nRST(nrst), .frame_start(fs),
        .req_valid(valid), .req_ready(ready), .req_slot(slot),
        .req_x(rx), .req_y(ry), .req_en(ren),
        .spr_x(sx), .spr_y(sy), .spr_en(sen),
        .commit_done(cd), .wr_err(werr)
    );

    typedef struct packed {
        logic [NS*16-1:0] x;
        logic [NS*16-1:0] y;
        logic [NS-1:0]    en;
    } tbl_t;

    tbl_t        cq[$];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] m_sx[NS];
    logic [15:0] m_sy[NS];
    logic        m_sen[NS];
    logic [NS-1:0] m_dirty;
    tbl_t        m_act, m_pend;
    logic        m_err, m_commit, m_cd;
    int          m_rr;

    logic [IW-1:0] d_slot[NR];
    logic [15:0]   d_x[NR];
    logic [15:0]   d_y[NR];
    logic          d_en[NR];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mv(input logic [15:0] v, input int lim);
        return (int'(v) == lim - 1) ? 16'd0 : v + 16'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_sx[i] = '0; m_sy[i] = '0; m_sen[i] = 1'b0;
        end
        m_dirty = '0; m_act = '0; m_pend = '0;
        m_err = 1'b0; m_commit = 1'b0; m_cd = 1'b0; m_rr = 0;
        cq.delete();
    endtask

    task automatic setreq(input int r, input int s, input int x, input int y, input logic en);
        d_slot[r] = IW'(s);
        d_x[r]    = 16'(x);
        d_y[r]    = 16'(y);
        d_en[r]   = en;
    endtask

    task automatic rst_dut();
        @(negedge clk);
        nrst = 1'b0; valid = '0; fs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        nrst = 1'b1;
    endtask

    // One clock: drive, check outputs of the previous edge, then advance the model over the next edge
    task automatic cycle(input logic [NR-1:0] v, input logic f);
        logic [NR-1:0] exp_rdy;
        tbl_t t;
        int g, idx, s;
        @(negedge clk);
        valid = v; fs = f;
        for (int i = 0; i < NR; i++) begin
            slot[i*IW +: IW] = d_slot[i];
            rx[i*16 +: 16]   = d_x[i];
            ry[i*16 +: 16]   = d_y[i];
            ren[i]           = d_en[i];
        end
        #1;
        check("commit_done", cd, m_cd);
        if (cd) begin
            check("commit_pending", cq.size() > 0, 1'b1);
            if (cq.size() > 0) begin
                t = cq.pop_front();
                check("commit_spr_x", sx, t.x);
                check("commit_spr_y", sy, t.y);
                check("commit_spr_en", sen, t.en);
            end
        end
        check("spr_x", sx, m_act.x);
        check("spr_y", sy, m_act.y);
        check("spr_en", sen, m_act.en);
        check("wr_err", werr, m_err);
        exp_rdy = '0;
        g = -1;
        if (!m_commit) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                if (g < 0 && v[idx]) g = idx;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        check("req_ready", ready, exp_rdy);
        m_cd = m_commit;
        if (m_commit) begin
            m_act = m_pend;
            for (int i = 0; i < NS; i++) begin
                m_sx[i] = m_pend.x[i*16 +: 16];
                m_sy[i] = m_pend.y[i*16 +: 16];
            end
            m_dirty  = '0;
            m_commit = 1'b0;
        end else begin
            if (g >= 0) begin
                m_rr = (g + 1) % NR;
                if (int'(d_slot[g]) < NS) begin
                    s = int'(d_slot[g]);
                    m_sx[s]    = (int'(d_x[g]) >= HM) ? 16'd0 : d_x[g];
                    m_sy[s]    = (int'(d_y[g]) >= VM) ? 16'd0 : d_y[g];
                    m_sen[s]   = d_en[g];
                    m_dirty[s] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (f) begin
                m_commit = 1'b1;
                for (int i = 0; i < NS; i++) begin
                    m_pend.x[i*16 +: 16] = m_sx[i];
                    m_pend.y[i*16 +: 16] = m_sy[i];
`ifdef SPR_AUTOMOVE_EN
                    if (!m_dirty[i]) begin
                        m_pend.x[i*16 +: 16] = mv(m_sx[i], HM);
                        m_pend.y[i*16 +: 16] = mv(m_sy[i], VM);
                    end
`endif
                    m_pend.en[i] = m_sen[i];
                end
                cq.push_back(m_pend);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) setreq(r, 0, 0, 0, 1'b0);
        model_reset();
        // reset state
        rst_dut();
        cycle(2'b00, 0); cycle(2'b00, 0);
        // buffering: nothing visible until the commit
        setreq(0, 1, 100, 50, 1'b1);
        setreq(1, 2, 200, 100, 1'b1);
        cycle(2'b01, 0); cycle(2'b00, 0); cycle(2'b00, 0);
        cycle(2'b00, 1);
        cycle(2'b11, 0);
        // round robin with both requesters valid, then only req1
        cycle(2'b11, 0); cycle(2'b11, 0); cycle(2'b11, 0); cycle(2'b11, 0);
        setreq(0, 0, 11, 12, 1'b1);
        cycle(2'b01, 0);
        setreq(1, 3, 21, 22, 1'b0);
        cycle(2'b10, 0); cycle(2'b10, 0); cycle(2'b10, 0);
        // coordinate wrap, exact boundary, out-of-range slot
        setreq(0, 3, 480, 272, 1'b1);
        setreq(1, 1, 479, 271, 1'b0);
        cycle(2'b11, 0); cycle(2'b11, 0);
        setreq(0, 4, 5, 5, 1'b1);
        cycle(2'b01, 0); cycle(2'b01, 0);
        cycle(2'b00, 1); cycle(2'b00, 0); cycle(2'b00, 0); cycle(2'b00, 0);
        // transfer on the frame_start edge, frame_start ignored in commit
        setreq(1, 0, 7, 8, 1'b1);
        cycle(2'b10, 1);
        setreq(1, 2, 9, 9, 1'b1);
        cycle(2'b10, 1);
        cycle(2'b10, 0); cycle(2'b00, 0);
        // reset during the commit cycle
        setreq(0, 2, 33, 44, 1'b1);
        cycle(2'b01, 0); cycle(2'b00, 1);
        rst_dut();
        cycle(2'b00, 0); cycle(2'b00, 0);
        // unwritten slots across commits (moved when automove is built in)
        setreq(0, 0, 479, 271, 1'b1);
        cycle(2'b01, 0); cycle(2'b00, 1); cycle(2'b00, 0); cycle(2'b00, 0);
        setreq(1, 2, 10, 10, 1'b1);
        cycle(2'b10, 0); cycle(2'b00, 1); cycle(2'b00, 0); cycle(2'b00, 0); cycle(2'b00, 0);
        check("commit_queue_drained", cq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
